// File: rtl/line_matrix_prog.sv
// line_matrix_prog: timed select/strobe/reset sequencer for the accessory GPO line matrix.
// Optional macro LM_READBACK_EN adds a shadow table of committed routes readable via rd_addr/rd_data.
module line_matrix_prog #(
  parameter int SEL_W     = 4,
  parameter int SETUP_CYC = 4,
  parameter int HIGH_CYC  = 4,
  parameter int HOLD_CYC  = 4,
  parameter int RST_CYC   = 8,
  parameter int CNT_W     = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [SEL_W-1:0] cfg_input_sel,
  input  logic [SEL_W-1:0] cfg_output_sel,
  input  logic             clear_req,
  output logic             lm_clk,
  output logic             lm_rstn,
  output logic [SEL_W-1:0] lm_input_select,
  output logic [SEL_W-1:0] lm_output_select,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] route_count,
  input  logic [SEL_W-1:0] rd_addr,
  output logic [SEL_W:0]   rd_data
);
  typedef enum logic [2:0] {IDLE, CLEAR, SETUP, STROBE, HOLD} state_t;
  localparam int TW = 16;
  state_t state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic clear_pend_q, clear_pend_d;
  logic lm_clk_q, lm_rstn_q, done_q;
  logic [SEL_W-1:0] in_sel_q, in_sel_d, out_sel_q, out_sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic accept, commit, enter_clear, to_quiet;
  assign cfg_ready   = (state_q == IDLE) & ~clear_pend_q;
  assign accept      = cfg_valid & cfg_ready;
  assign commit      = (state_q == HOLD) && (tmr_q == '0);
  assign enter_clear = (state_d == CLEAR) && (state_q != CLEAR);
  assign to_quiet    = (state_d == IDLE) || (state_d == CLEAR);
  always_comb begin
    state_d = state_q;
    tmr_d   = (tmr_q == '0) ? '0 : tmr_q - 1'b1;
    case (state_q)
      IDLE: begin
        if (clear_pend_q) begin
          state_d = CLEAR;
          tmr_d   = TW'(RST_CYC - 1);
        end else if (cfg_valid) begin
          state_d = SETUP;
          tmr_d   = TW'(SETUP_CYC - 1);
        end
      end
      CLEAR: state_d = (tmr_q == '0) ? IDLE : CLEAR;
      SETUP: begin
        if (tmr_q == '0) begin
          state_d = STROBE;
          tmr_d   = TW'(HIGH_CYC - 1);
        end
      end
      STROBE: begin
        if (tmr_q == '0) begin
          state_d = HOLD;
          tmr_d   = TW'(HOLD_CYC - 1);
        end
      end
      HOLD: state_d = (tmr_q == '0) ? IDLE : HOLD;
      default: begin
        state_d = CLEAR;
        tmr_d   = TW'(RST_CYC - 1);
      end
    endcase
  end
  // selects only move when a route is latched or the matrix goes quiet, never mid-strobe
  always_comb begin
    in_sel_d     = accept ? cfg_input_sel : to_quiet ? '0 : in_sel_q;
    out_sel_d    = accept ? cfg_output_sel : to_quiet ? '0 : out_sel_q;
    clear_pend_d = clear_req | (clear_pend_q & (state_q != IDLE));
    cnt_d        = enter_clear ? '0 : (commit && ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= CLEAR;
      tmr_q        <= TW'(RST_CYC - 1);
      clear_pend_q <= 1'b0;
      lm_clk_q     <= 1'b0;
      lm_rstn_q    <= 1'b0;
      done_q       <= 1'b0;
      in_sel_q     <= '0;
      out_sel_q    <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      clear_pend_q <= clear_pend_d;
      lm_clk_q     <= (state_d == STROBE);
      lm_rstn_q    <= (state_d != CLEAR);
      done_q       <= (state_d == IDLE) && (state_q != IDLE);
      in_sel_q     <= in_sel_d;
      out_sel_q    <= out_sel_d;
      cnt_q        <= cnt_d;
    end
  end
  assign lm_clk           = lm_clk_q;
  assign lm_rstn          = lm_rstn_q;
  assign lm_input_select  = in_sel_q;
  assign lm_output_select = out_sel_q;
  assign busy             = (state_q != IDLE);
  assign done             = done_q;
  assign route_count      = cnt_q;
`ifdef LM_READBACK_EN
  localparam int N = 1 << SEL_W;
  logic [N-1:0] vld_q;
  logic [SEL_W-1:0] tbl_q [N];
  logic [SEL_W:0] rd_q;
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      vld_q <= '0;
      rd_q  <= '0;
    end else begin
      if (state_q == CLEAR) vld_q <= '0;
      else if (commit) vld_q[out_sel_q] <= 1'b1;
      rd_q <= vld_q[rd_addr] ? {1'b1, tbl_q[rd_addr]} : '0;
    end
  end
  always_ff @(posedge sys_clk) begin
    if (commit) tbl_q[out_sel_q] <= in_sel_q;
  end
  assign rd_data = rd_q;
`else
  logic unused_rd;
  assign unused_rd = ^rd_addr;
  assign rd_data   = '0;
`endif
endmodule

// File: tb/tb_line_matrix_prog.sv
// tb_line_matrix_prog: directed bench for line_matrix_prog with hand-computed expectations.
module tb_line_matrix_prog;
  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic cfg_valid = 1'b0;
  logic cfg_ready;
  logic [3:0] cfg_input_sel = '0;
  logic [3:0] cfg_output_sel = '0;
  logic clear_req = 1'b0;
  logic lm_clk, lm_rstn, busy, done;
  logic [3:0] lm_input_select, lm_output_select;
  logic [7:0] route_count;
  logic [3:0] rd_addr = '0;
  logic [4:0] rd_data;
  int checks = 0;
  int failures = 0;
  logic [15:0] clk_tr, done_tr;
  int sel_ok, wait_n, n;
  logic rdy13, sel13_zero, rdy_seen, clk_seen;
  logic [7:0] cnt13;

  line_matrix_prog dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_input_sel(cfg_input_sel), .cfg_output_sel(cfg_output_sel), .clear_req(clear_req),
    .lm_clk(lm_clk), .lm_rstn(lm_rstn), .lm_input_select(lm_input_select),
    .lm_output_select(lm_output_select), .busy(busy), .done(done),
    .route_count(route_count), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // called at a negedge; returns after sampling the done cycle (accept cycle + 13)
  task automatic run_route(input logic [3:0] in_v, input logic [3:0] out_v, input logic hold_valid,
                           input logic clr);
    cfg_input_sel = in_v;
    cfg_output_sel = out_v;
    cfg_valid = 1'b1;
    wait_n = 0;
    while (!cfg_ready && wait_n < 100) begin
      @(negedge sys_clk);
      wait_n++;
    end
    clk_tr = '0;
    done_tr = '0;
    sel_ok = 0;
    for (int k = 1; k <= 13; k++) begin
      @(negedge sys_clk);
      if (k == 1 && !hold_valid) cfg_valid = 1'b0;
      if (k == 6 && clr) clear_req = 1'b1;
      if (k == 7) clear_req = 1'b0;
      clk_tr[k] = lm_clk;
      done_tr[k] = done;
      if (k <= 12 && lm_input_select == in_v && lm_output_select == out_v) sel_ok++;
    end
    rdy13 = cfg_ready;
    sel13_zero = (lm_input_select == 4'd0) && (lm_output_select == 4'd0);
    cnt13 = route_count;
  endtask

  // called at a sample point inside CLEAR; counts low cycles of lm_rstn
  task automatic measure_clear();
    n = 0;
    rdy_seen = 1'b0;
    clk_seen = 1'b0;
    while (!lm_rstn && n < 50) begin
      n++;
      rdy_seen |= cfg_ready;
      clk_seen |= lm_clk;
      @(negedge sys_clk);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge sys_clk);
    check("rst_rstn", lm_rstn, 0);
    check("rst_clk", lm_clk, 0);
    check("rst_busy", busy, 1);
    check("rst_done", done, 0);
    check("rst_ready", cfg_ready, 0);
    check("rst_cnt", route_count, 0);
    check("rst_sel", {lm_input_select, lm_output_select}, 0);
    sys_rst = 1'b0;
    #1;
    measure_clear();
    check("boot_rstn_low", n, 8);
    check("boot_ready_in_clear", rdy_seen, 0);
    check("boot_done", done, 1);
    check("boot_ready", cfg_ready, 1);
    check("boot_busy", busy, 0);
    check("boot_cnt", route_count, 0);

    run_route(4'd3, 4'd5, 1'b0, 1'b0);
    check("r1_wait", wait_n, 0);
    check("r1_clk_trace", clk_tr, 16'h01E0);
    check("r1_done_trace", done_tr, 16'h2000);
    check("r1_sel_held", sel_ok, 12);
    check("r1_sel_zero", sel13_zero, 1);
    check("r1_ready", rdy13, 1);
    check("r1_cnt", cnt13, 1);

    run_route(4'd9, 4'd1, 1'b0, 1'b1);
    check("rc_clk_trace", clk_tr, 16'h01E0);
    check("rc_done_trace", done_tr, 16'h2000);
    check("rc_cnt", cnt13, 2);
    check("rc_ready_pend", rdy13, 0);
    @(negedge sys_clk);
    measure_clear();
    check("rc_rstn_low", n, 8);
    check("rc_ready_in_clear", rdy_seen, 0);
    check("rc_done", done, 1);
    check("rc_cnt_zero", route_count, 0);
    check("rc_ready_after", cfg_ready, 1);

    for (int r = 0; r < 4; r++) begin
      run_route(4'(r + 2), 4'(15 - r), (r != 3), 1'b0);
      check("b2b_wait", wait_n, 0);
      check("b2b_clk_trace", clk_tr, 16'h01E0);
      check("b2b_sel_held", sel_ok, 12);
      check("b2b_done_trace", done_tr, 16'h2000);
    end
    check("b2b_cnt", route_count, 4);

    cfg_input_sel = 4'd6;
    cfg_output_sel = 4'd7;
    cfg_valid = 1'b1;
    @(negedge sys_clk);
    cfg_valid = 1'b0;
    check("ar_in_setup", {lm_input_select, lm_output_select}, 8'h67);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    #1;
    check("ar_rstn", lm_rstn, 0);
    check("ar_clk", lm_clk, 0);
    check("ar_sel", {lm_input_select, lm_output_select}, 0);
    check("ar_busy_ready", {busy, cfg_ready, done}, 3'b100);
    check("ar_cnt", route_count, 0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    #1;
    measure_clear();
    check("ar_rstn_low", n, 8);
    check("ar_no_clk", clk_seen, 0);
    check("ar_done", done, 1);
    check("ar_cnt_after", route_count, 0);

    run_route(4'd7, 4'd2, 1'b0, 1'b0);
    run_route(4'd1, 4'd2, 1'b0, 1'b0);
    check("rb_cnt", route_count, 2);
    rd_addr = 4'd2;
    @(negedge sys_clk);
`ifdef LM_READBACK_EN
    check("rb_addr2", rd_data, 5'h11);
`else
    check("rb_addr2", rd_data, 5'h00);
`endif
    rd_addr = 4'd4;
    @(negedge sys_clk);
    check("rb_addr4", rd_data, 5'h00);
    clear_req = 1'b1;
    @(negedge sys_clk);
    clear_req = 1'b0;
    wait_n = 0;
    while (!done && wait_n < 50) begin
      @(negedge sys_clk);
      wait_n++;
    end
    check("rb_clear_done", done, 1);
    rd_addr = 4'd2;
    @(negedge sys_clk);
    check("rb_addr2_cleared", rd_data, 5'h00);
    check("rb_cnt_cleared", route_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
